// File: rtl/dnn_ctrl_pkg.sv
// Shared types and sizing for the MNIST inference sequencer and its argmax helper.
package dnn_ctrl_pkg;

    localparam int DATA_WIDTH  = 3;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_WIDTH   = 4;

    typedef logic signed [DATA_WIDTH-1:0] score_t;
    typedef logic [IDX_WIDTH-1:0]         idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_START,
        ST_WAIT_DONE,
        ST_SCAN,
        ST_RESULT
    } ctrl_state_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_CLASSES - 1);

endpackage

// File: rtl/dnn_infer_ctrl_if.sv
// Host-side request/result handshake of the inference sequencer.
interface dnn_infer_ctrl_if;
    import dnn_ctrl_pkg::*;

    logic   req_valid;
    logic   req_ready;
    logic   res_valid;
    logic   res_ready;
    idx_t   res_class;
    score_t res_score;
    logic   res_err;

    modport master (
        output req_valid, res_ready,
        input  req_ready, res_valid, res_class, res_score, res_err
    );

    modport slave (
        input  req_valid, res_ready,
        output req_ready, res_valid, res_class, res_score, res_err
    );

endinterface

// File: rtl/dnn_argmax_seq.sv
// Streaming argmax: one score per sample cycle, keeps the first (lowest-index) maximum.
module dnn_argmax_seq
    import dnn_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   sample,
    input  logic   first,
    input  idx_t   idx,
    input  score_t score,
    output idx_t   best_idx,
    output score_t best_score
);

    // NOTE: state flops use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            best_idx   <= '0;
            best_score <= '0;
        end else if (sample && (first || score > best_score)) begin
            best_idx   <= idx;
            best_score <= score;
        end
    end

endmodule

// File: rtl/dnn_infer_ctrl.sv
// Sequencer: clear/start the MNIST core, wait for done, argmax-scan the outputs, return the digit.
// Optional watchdog in WAIT_DONE enabled by `define DNN_TIMEOUT_EN.
module dnn_infer_ctrl
    import dnn_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    dnn_infer_ctrl_if.slave      host,
    output logic                 core_reset,
    output logic                 core_start,
    input  logic                 core_done,
    output idx_t                 core_out_idx,
    input  score_t               core_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] infer_cnt
);

    ctrl_state_t state;
    idx_t        idx;
    logic        done_armed;
    logic        req_ready_q;
    logic        res_valid_q;
    logic        res_err_q;
    logic        timeout_hit;
    idx_t        best_idx;
    score_t      best_score;

`ifdef DNN_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] wd_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT_DONE) wd_cnt <= '0;
        else                              wd_cnt <= wd_cnt + 1'b1;
    end

    // A done seen in the same cycle as expiry still wins over the abort.
    assign timeout_hit = (state == ST_WAIT_DONE)
                       && (wd_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1))
                       && !(done_armed && core_done);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    dnn_argmax_seq u_argmax (
        .clk        (clk),
        .rst        (rst),
        .clear      (timeout_hit),
        .sample     (state == ST_SCAN),
        .first      (idx == '0),
        .idx        (idx),
        .score      (core_out),
        .best_idx   (best_idx),
        .best_score (best_score)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            done_armed  <= 1'b0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            core_reset  <= 1'b0;
            core_start  <= 1'b0;
            busy        <= 1'b0;
            infer_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (host.req_valid) begin
                        state       <= ST_CLEAR;
                        core_reset  <= 1'b1;
                        req_ready_q <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state      <= ST_START;
                    core_reset <= 1'b0;
                    core_start <= 1'b1;
                end
                ST_START: begin
                    state      <= ST_WAIT_DONE;
                    core_start <= 1'b0;
                    done_armed <= 1'b0;
                end
                ST_WAIT_DONE: begin
                    // First WAIT_DONE cycle only arms: a done still high from the last run is stale.
                    done_armed <= 1'b1;
                    if (done_armed && core_done) begin
                        state <= ST_SCAN;
                        idx   <= '0;
                    end else if (timeout_hit) begin
                        state       <= ST_RESULT;
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (idx == LAST_IDX) begin
                        state       <= ST_RESULT;
                        idx         <= '0;
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (host.res_ready) begin
                        state       <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                        busy        <= 1'b0;
                        infer_cnt   <= infer_cnt + 1'b1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    idx         <= '0;
                    req_ready_q <= 1'b1;
                    res_valid_q <= 1'b0;
                    res_err_q   <= 1'b0;
                    core_reset  <= 1'b0;
                    core_start  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // idx is held at zero outside SCAN, so it drives the mux select directly.
    assign core_out_idx   = idx;
    assign host.req_ready = req_ready_q;
    assign host.res_valid = res_valid_q;
    assign host.res_class = best_idx;
    assign host.res_score = best_score;
    assign host.res_err   = res_err_q;

endmodule

// File: tb/tb_dnn_infer_ctrl.sv
// Directed bench for dnn_infer_ctrl: behavioural core (score table + done timing) and result checks.
module tb_dnn_infer_ctrl;
    import dnn_ctrl_pkg::*;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             core_reset;
    logic             core_start;
    logic             core_done;
    idx_t             core_out_idx;
    score_t           core_out;
    logic             busy;
    logic [CNT_W-1:0] infer_cnt;

    score_t scores [NUM_CLASSES];
    int     n_checks = 0;
    int     n_errors = 0;
    int     exp_cnt  = 0;
    int     lat;
    bit     found;

    dnn_infer_ctrl_if host();

    assign core_out = (core_out_idx < idx_t'(NUM_CLASSES)) ? scores[core_out_idx] : '0;

    dnn_infer_ctrl #(.CNT_WIDTH(CNT_W), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (host),
        .core_reset   (core_reset),
        .core_start   (core_start),
        .core_done    (core_done),
        .core_out_idx (core_out_idx),
        .core_out     (core_out),
        .busy         (busy),
        .infer_cnt    (infer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_scores(input int v [NUM_CLASSES]);
        for (int i = 0; i < NUM_CLASSES; i++) scores[i] = score_t'(v[i]);
    endtask

    // Cycle n counts from the CLEAR cycle (n=1); START is n=2, done rises in cycle 2+d.
    function automatic logic done_level(input int n, input int d, input bit stale);
        if (stale && n <= 3) return 1'b1;
        return (n >= 2 + d);
    endfunction

    // Issue a request from IDLE; lat = rising edges from the accept edge to first res_valid, -1 if none.
    task automatic run_infer(input int d, input bit stale, input bit keep_req, output int lat_o);
        lat_o = -1;
        host.req_valid = 1'b1;
        @(negedge clk);
        host.req_valid = keep_req;
        check("clear_pulse", core_reset, 1);
        check("no_start_in_clear", core_start, 0);
        check("busy_in_clear", busy, 1);
        for (int n = 1; n <= 60; n++) begin
            core_done = done_level(n, d, stale);
            if (n == 2) check("start_pulse", core_start, 1);
            if (host.res_valid) begin
                lat_o = n - 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic take_result();
        host.res_ready = 1'b1;
        @(negedge clk);
        host.res_ready = 1'b0;
        exp_cnt++;
        check("infer_cnt", infer_cnt, exp_cnt);
        check("idle_req_ready", host.req_ready, 1);
        check("res_valid_drop", host.res_valid, 0);
        check("idle_not_busy", busy, 0);
    endtask

    initial begin
        rst            = 1'b1;
        host.req_valid = 1'b0;
        host.res_ready = 1'b0;
        core_done      = 1'b0;
        set_scores('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", host.req_ready, 1);
        check("rst_res_valid", host.res_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_core_reset", core_reset, 0);
        check("rst_core_start", core_start, 0);
        check("rst_out_idx", core_out_idx, 0);
        check("rst_cnt", infer_cnt, 0);
        check("rst_res_err", host.res_err, 0);
        check("rst_res_class", host.res_class, 0);
        @(negedge clk);

        // Basic
        set_scores('{-1, 0, 2, 1, -4, 3, 0, 0, 1, -2});
        run_infer(5, 1'b0, 1'b0, lat);
        check("basic_latency", lat, 17);
        check("basic_class", host.res_class, 5);
        check("basic_score", host.res_score, 3);
        check("basic_err", host.res_err, 0);
        check("basic_req_ready", host.req_ready, 0);
        take_result();

        // Tie between negatives keeps the lower index
        set_scores('{-3, -3, -1, -3, -3, -3, -3, -1, -3, -3});
        run_infer(2, 1'b0, 1'b0, lat);
        check("tie_latency", lat, 14);
        check("tie_class", host.res_class, 2);
        check("tie_score", host.res_score, -1);
        take_result();

        set_scores('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        run_infer(3, 1'b0, 1'b0, lat);
        check("zero_class", host.res_class, 0);
        check("zero_score", host.res_score, 0);
        take_result();

        set_scores('{-4, -4, -4, -4, -4, -4, -4, -4, -4, 3});
        run_infer(2, 1'b0, 1'b0, lat);
        check("last_class", host.res_class, 9);
        check("last_score", host.res_score, 3);
        take_result();

        // Stale done held into the first WAIT_DONE cycle
        set_scores('{-1, 0, 2, 1, -4, 3, 0, 0, 1, -2});
        run_infer(5, 1'b1, 1'b0, lat);
        check("stale_latency", lat, 17);
        check("stale_class", host.res_class, 5);
        take_result();

        // Backpressure with req_valid held high throughout
        run_infer(5, 1'b0, 1'b1, lat);
        check("bp_latency", lat, 17);
        for (int i = 0; i < 20; i++) begin
            check("bp_valid", host.res_valid, 1);
            check("bp_class", host.res_class, 5);
            check("bp_score", host.res_score, 3);
            check("bp_req_ready", host.req_ready, 0);
            check("bp_no_clear", core_reset, 0);
            @(negedge clk);
        end
        take_result();
        @(negedge clk);
        check("bp_next_clear", core_reset, 1);
        host.req_valid = 1'b0;

        // Reset in the middle of SCAN at idx=4
        found = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            core_done = done_level(n, 5, 1'b0);
            if (core_out_idx == idx_t'(4)) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("scan_reached_idx4", found, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        check("mrst_busy", busy, 0);
        check("mrst_req_ready", host.req_ready, 1);
        check("mrst_res_valid", host.res_valid, 0);
        check("mrst_out_idx", core_out_idx, 0);
        check("mrst_cnt", infer_cnt, 0);
        for (int i = 0; i < 3; i++) begin
            check("mrst_no_start", core_start, 0);
            check("mrst_no_clear", core_reset, 0);
            @(negedge clk);
        end
        run_infer(5, 1'b0, 1'b0, lat);
        check("post_rst_latency", lat, 17);
        check("post_rst_class", host.res_class, 5);
        take_result();

        // Done never arrives
        run_infer(1000, 1'b0, 1'b0, lat);
`ifdef DNN_TIMEOUT_EN
        check("to_latency", lat, 10);
        check("to_err", host.res_err, 1);
        check("to_class", host.res_class, 0);
        check("to_score", host.res_score, 0);
        take_result();
`else
        check("no_to_result", lat, -1);
        check("no_to_valid", host.res_valid, 0);
        check("no_to_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
